// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - FSM encoding, shift-field width and saturation limits for conv_mac_array (CONV_MAC_RELU_EN)
package conv_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ACC   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_OUT   = 2'd3;

  localparam int SHIFT_W = 6;

  // Signed result limits for a given output width.
  function automatic longint sat_max(input int bits);
    return (longint'(1) <<< (bits - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int bits);
    return -(longint'(1) <<< (bits - 1));
  endfunction

endpackage

// File: rtl/conv_mac_lane.sv
// rtl/conv_mac_lane.sv - one MAC lane: tap products, two-stage accumulate, round/shift/saturate (CONV_MAC_RELU_EN)
module conv_mac_lane
  import conv_pkg::*;
#(
  parameter int N_TAP   = 3,
  parameter int B_PIXEL = 16,
  parameter int B_ACC   = 40
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     beat,
  input  logic                     clr,
  input  logic                     load,
  input  logic [SHIFT_W-1:0]       shift,
  input  logic [N_TAP*B_PIXEL-1:0] wei,
  input  logic [N_TAP*B_PIXEL-1:0] act,
  output logic [B_PIXEL-1:0]       result
);

  localparam logic signed [B_ACC-1:0] SAT_HI = B_ACC'(sat_max(B_PIXEL));
  localparam logic signed [B_ACC-1:0] SAT_LO = B_ACC'(sat_min(B_PIXEL));

  logic signed [2*B_PIXEL-1:0] prod;
  logic signed [B_ACC-1:0]     tap_sum;
  logic signed [B_ACC-1:0]     s1_sum;
  logic                        s1_vld;
  logic signed [B_ACC-1:0]     acc;
  logic signed [B_ACC-1:0]     total;
  logic signed [B_ACC-1:0]     rounded;
  logic signed [B_ACC-1:0]     shifted;
  logic [B_PIXEL-1:0]          sat_val;

  always_comb begin
    tap_sum = '0;
    prod    = '0;
    for (int t = 0; t < N_TAP; t++) begin
      prod    = $signed(wei[t*B_PIXEL +: B_PIXEL]) * $signed(act[t*B_PIXEL +: B_PIXEL]);
      tap_sum = tap_sum + {{(B_ACC-2*B_PIXEL){prod[2*B_PIXEL-1]}}, prod};
    end
  end

  // The result register loads in DRAIN, while the last beat is still in stage 1,
  // so fold it in here to meet the two-cycle latency.
  always_comb begin
    total   = acc + (s1_vld ? s1_sum : '0);
    rounded = total + ((shift != '0) ? (B_ACC'(1) <<< (shift - SHIFT_W'(1))) : '0);
    shifted = rounded >>> shift;
    if (shifted > SAT_HI)
      sat_val = SAT_HI[B_PIXEL-1:0];
    else if (shifted < SAT_LO)
      sat_val = SAT_LO[B_PIXEL-1:0];
    else
      sat_val = shifted[B_PIXEL-1:0];
`ifdef CONV_MAC_RELU_EN
    if (sat_val[B_PIXEL-1])
      sat_val = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_sum <= '0;
      s1_vld <= 1'b0;
      acc    <= '0;
      result <= '0;
    end else begin
      s1_vld <= beat;
      if (beat)
        s1_sum <= tap_sum;
      if (clr)
        acc <= '0;
      else if (s1_vld)
        acc <= acc + s1_sum;
      if (load)
        result <= sat_val;
    end
  end

endmodule

// File: rtl/conv_mac_array.sv
// rtl/conv_mac_array.sv - N_LANE convolution MAC array with job FSM (optional CONV_MAC_RELU_EN)
module conv_mac_array
  import conv_pkg::*;
#(
  parameter int N_LANE  = 4,
  parameter int N_TAP   = 3,
  parameter int B_PIXEL = 16,
  parameter int B_ACC   = 40,
  parameter int B_CNT   = 12
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            start,
  input  logic [B_CNT-1:0]                cfg_len,
  input  logic [B_CNT-1:0]                cfg_nout,
  input  logic [SHIFT_W-1:0]              cfg_shift,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [N_LANE*N_TAP*B_PIXEL-1:0] in_wei,
  input  logic [N_LANE*N_TAP*B_PIXEL-1:0] in_act,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [N_LANE*B_PIXEL-1:0]       out_data,
  output logic                            busy,
  output logic                            done
);

  state_t             state;
  logic [B_CNT-1:0]   beat_cnt;
  logic [B_CNT-1:0]   out_cnt;
  logic [B_CNT-1:0]   len_q;
  logic [B_CNT-1:0]   nout_q;
  logic [SHIFT_W-1:0] shift_q;
  logic               xfer;
  logic               last_beat;
  logic               out_hs;
  logic               last_out;

  assign in_ready  = (state == ST_ACC);
  assign out_valid = (state == ST_OUT);
  assign busy      = (state != ST_IDLE);
  assign xfer      = in_valid && in_ready;
  assign last_beat = (beat_cnt == len_q - B_CNT'(1));
  assign out_hs    = out_valid && out_ready;
  assign last_out  = (out_cnt == nout_q - B_CNT'(1));
  assign done      = out_hs && last_out;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= ST_IDLE;
      beat_cnt <= '0;
      out_cnt  <= '0;
      len_q    <= '0;
      nout_q   <= '0;
      shift_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && cfg_len != '0 && cfg_nout != '0) begin
            len_q    <= cfg_len;
            nout_q   <= cfg_nout;
            shift_q  <= cfg_shift;
            beat_cnt <= '0;
            out_cnt  <= '0;
            state    <= ST_ACC;
          end
        end
        ST_ACC: begin
          if (xfer) begin
            beat_cnt <= beat_cnt + B_CNT'(1);
            if (last_beat)
              state <= ST_DRAIN;
          end
        end
        ST_DRAIN: state <= ST_OUT;
        ST_OUT: begin
          if (out_ready) begin
            beat_cnt <= '0;
            out_cnt  <= out_cnt + B_CNT'(1);
            state    <= last_out ? ST_IDLE : ST_ACC;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar l = 0; l < N_LANE; l++) begin : g_lane
    conv_mac_lane #(
      .N_TAP   (N_TAP),
      .B_PIXEL (B_PIXEL),
      .B_ACC   (B_ACC)
    ) u_lane (
      .clk    (clk),
      .rstn   (rstn),
      .beat   (xfer),
      .clr    (out_hs),
      .load   (state == ST_DRAIN),
      .shift  (shift_q),
      .wei    (in_wei[l*N_TAP*B_PIXEL +: N_TAP*B_PIXEL]),
      .act    (in_act[l*N_TAP*B_PIXEL +: N_TAP*B_PIXEL]),
      .result (out_data[l*B_PIXEL +: B_PIXEL])
    );
  end

endmodule

// File: tb/tb_conv_mac_array.sv
// tb/tb_conv_mac_array.sv - scoreboard bench for conv_mac_array (honours CONV_MAC_RELU_EN)
module tb_conv_mac_array;

  localparam int N_LANE  = 4;
  localparam int N_TAP   = 3;
  localparam int B_PIXEL = 16;
  localparam int B_ACC   = 40;
  localparam int B_CNT   = 12;
  localparam int IW      = N_LANE*N_TAP*B_PIXEL;
  localparam int OW      = N_LANE*B_PIXEL;

  logic              clk;
  logic              rstn;
  logic              start;
  logic [B_CNT-1:0]  cfg_len;
  logic [B_CNT-1:0]  cfg_nout;
  logic [5:0]        cfg_shift;
  logic              in_valid;
  logic              in_ready;
  logic [IW-1:0]     in_wei;
  logic [IW-1:0]     in_act;
  logic              out_valid;
  logic              out_ready;
  logic [OW-1:0]     out_data;
  logic              busy;
  logic              done;

  int errors = 0;
  int checks = 0;
  logic [OW-1:0] sb[$];
  longint lane_acc [N_LANE];

  conv_mac_array #(
    .N_LANE (N_LANE), .N_TAP (N_TAP), .B_PIXEL (B_PIXEL), .B_ACC (B_ACC), .B_CNT (B_CNT)
  ) dut (
    .clk (clk), .rstn (rstn), .start (start), .cfg_len (cfg_len), .cfg_nout (cfg_nout),
    .cfg_shift (cfg_shift), .in_valid (in_valid), .in_ready (in_ready), .in_wei (in_wei),
    .in_act (in_act), .out_valid (out_valid), .out_ready (out_ready), .out_data (out_data),
    .busy (busy), .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [B_PIXEL-1:0] model(input longint s, input int sh);
    logic signed [B_ACC-1:0] a;
    longint v, hi, lo;
    hi = (longint'(1) <<< (B_PIXEL-1)) - 1;
    lo = -hi - 1;
    a = B_ACC'(s);
    if (sh > 0) a = a + (B_ACC'(1) <<< (sh-1));
    a = a >>> sh;
    v = longint'(a);
    if (v > hi) v = hi;
    else if (v < lo) v = lo;
`ifdef CONV_MAC_RELU_EN
    if (v < 0) v = 0;
`endif
    return B_PIXEL'(v);
  endfunction

  task automatic make_beat(input int mode, output logic [IW-1:0] w, output logic [IW-1:0] a);
    logic [B_PIXEL-1:0] wv, av;
    w = '0;
    a = '0;
    for (int l = 0; l < N_LANE; l++) begin
      for (int t = 0; t < N_TAP; t++) begin
        case (mode)
          0: begin wv = B_PIXEL'(2); av = B_PIXEL'(2); end
          1: begin
            wv = (t == 2) ? B_PIXEL'(0) : B_PIXEL'(2);
            av = (t == 0) ? B_PIXEL'(3) : (t == 1) ? B_PIXEL'(2) : B_PIXEL'(5);
          end
          2: begin
            wv = (t == 0) ? B_PIXEL'(3) : (t == 1) ? B_PIXEL'(2) : B_PIXEL'(0);
            av = wv;
          end
          3: begin wv = 16'h7FFF; av = 16'h7FFF; end
          4: begin wv = 16'h7FFF; av = 16'h8000; end
          default: begin wv = B_PIXEL'($urandom); av = B_PIXEL'($urandom); end
        endcase
        w[(l*N_TAP+t)*B_PIXEL +: B_PIXEL] = wv;
        a[(l*N_TAP+t)*B_PIXEL +: B_PIXEL] = av;
        lane_acc[l] += longint'($signed(wv)) * longint'($signed(av));
      end
    end
  endtask

  task automatic pulse_start(input int len, input int nout, input int sh);
    start     = 1'b1;
    cfg_len   = B_CNT'(len);
    cfg_nout  = B_CNT'(nout);
    cfg_shift = 6'(sh);
    tick();
    start = 1'b0;
  endtask

  task automatic do_job(input string name, input int len, input int nout, input int sh,
                        input int mode, input int stall_idx, input int stall_n,
                        input bit gap, input bit poke);
    logic [IW-1:0] w, a;
    logic [OW-1:0] exp, held;
    int budget;
    bit stall_bad;
    pulse_start(len, nout, sh);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL %s start_busy got=%b want=1", name, busy); end
    for (int k = 0; k < nout; k++) begin
      for (int l = 0; l < N_LANE; l++) lane_acc[l] = 0;
      for (int b = 0; b < len; b++) begin
        if (gap) repeat ($urandom_range(0, 2)) tick();
        make_beat(mode, w, a);
        in_wei = w;
        in_act = a;
        in_valid = 1'b1;
        if (poke && b == 1) begin
          start = 1'b1; cfg_len = B_CNT'(1); cfg_nout = B_CNT'(1); cfg_shift = 6'd0;
        end
        budget = 0;
        while (in_ready !== 1'b1 && budget < 50) begin tick(); budget++; end
        if (budget >= 50) begin
          checks++; errors++;
          $display("FAIL %s in_ready_timeout got=%b want=1", name, in_ready);
        end
        tick();
        start = 1'b0;
        in_valid = 1'b0;
      end
      exp = '0;
      for (int l = 0; l < N_LANE; l++) exp[l*B_PIXEL +: B_PIXEL] = model(lane_acc[l], sh);
      sb.push_back(exp);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL %s early_valid out%0d got=%b want=0", name, k, out_valid); end
      tick();
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL %s latency out%0d got=%b want=1", name, k, out_valid); end
      if (k == stall_idx) begin
        held = out_data;
        stall_bad = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          tick();
          if (out_data !== held || in_ready !== 1'b0 || out_valid !== 1'b1) stall_bad = 1'b1;
        end
        checks++;
        if (stall_bad) begin errors++; $display("FAIL %s stall_hold out%0d got=%h want=%h", name, k, out_data, held); end
      end
      checks++;
      if (sb.size() == 0) begin
        errors++; $display("FAIL %s scoreboard_empty out%0d got=%h", name, k, out_data);
      end else begin
        exp = sb.pop_front();
        if (out_data !== exp) begin errors++; $display("FAIL %s data out%0d got=%h want=%h", name, k, out_data, exp); end
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (done !== 1'(k == nout-1)) begin errors++; $display("FAIL %s done out%0d got=%b want=%b", name, k, done, (k == nout-1)); end
      tick();
      out_ready = 1'b0;
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL %s end_idle got busy=%b done=%b want 0 0", name, busy, done); end
  endtask

  task automatic check_reset_vals(input string name);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL %s got valid=%b ready=%b busy=%b done=%b data=%h want all 0",
               name, out_valid, in_ready, busy, done, out_data);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; cfg_len = '0; cfg_nout = '0; cfg_shift = '0;
    in_valid = 1'b0; in_wei = '0; in_act = '0; out_ready = 1'b0;
    repeat (3) tick();
    check_reset_vals("reset");
    rstn = 1'b1;
    tick();
    check_reset_vals("reset_release");
  endtask

  task automatic test_basic();
    do_job("basic_twos", 1, 1, 0, 0, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_round_shift();
    do_job("round_sh2", 4, 1, 2, 1, -1, 0, 1'b0, 1'b0);
    do_job("round_sh3", 1, 1, 3, 2, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_saturate();
    do_job("sat_pos", 4, 1, 0, 3, -1, 0, 1'b0, 1'b0);
    do_job("sat_neg", 4, 1, 0, 4, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_stall();
    do_job("stall_nout3", 3, 3, 14, 5, 1, 5, 1'b1, 1'b0);
  endtask

  task automatic test_start_ignored();
    pulse_start(0, 1, 0);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL len0_start got busy=%b want=0", busy); end
    pulse_start(3, 0, 0);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL nout0_start got busy=%b want=0", busy); end
    do_job("start_while_busy", 4, 2, 12, 5, -1, 0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    logic [IW-1:0] w, a;
    pulse_start(8, 1, 0);
    for (int b = 0; b < 3; b++) begin
      make_beat(5, w, a);
      in_wei = w; in_act = a; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    rstn = 1'b0;
    tick();
    check_reset_vals("reset_mid");
    rstn = 1'b1;
    tick();
    check_reset_vals("reset_mid_release");
    do_job("after_reset", 2, 1, 0, 0, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_job("b2b_random", 2, 4, 13, 5, -1, 0, 1'b1, 1'b0);
    do_job("b2b_wrap_len1", 1, 2, 15, 5, -1, 0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_shift();
    test_saturate();
    test_stall();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
